// File: rtl/aoi_mon_pkg.sv
// Shared types and default configuration for the aoi2 output monitor.
package aoi_mon_pkg;

   // Default configuration; the monitor's parameters default to these.
   localparam int AOI_SYNC_STAGES   = 2;
   localparam int AOI_STABLE_CYCLES = 4;
   localparam int AOI_CNT_W         = 16;
   localparam int AOI_FIFO_DEPTH    = 4;

   // One logged level change: the new filtered level and when it happened.
   // "time" is a keyword, hence "stamp".
   typedef struct packed {
      logic                 level;
      logic [AOI_CNT_W-1:0] stamp;
   } aoi_evt_t;

   localparam int AOI_EVT_W = $bits(aoi_evt_t);

endpackage

// File: rtl/aoi_evt_fifo.sv
// Small synchronous event FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate counter. Besides the
// usual flags it exposes the head that will be current after this edge,
// so the owner can register its outputs without an extra cycle of latency
// on pops.
module aoi_evt_fifo
   import aoi_mon_pkg::*;
#(
   parameter int DW    = AOI_EVT_W,
   parameter int DEPTH = AOI_FIFO_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic          nxt_avail,
   output logic [DW-1:0] nxt_data
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic          do_push_s;
   logic          do_pop_s;
   logic [AW:0]   count_s;
   logic [AW:0]   left_s;

   // Occupancy flags and the accepted push/pop for this edge.
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop_s  = pop && !empty;
      // A pop in the same cycle frees the slot a full FIFO needs.
      do_push_s = push && (!full || do_pop_s);
      count_s   = wr_ptr_q - rd_ptr_q;
      // Pushes are left out on purpose: a new entry shows one edge later.
      left_s    = count_s - {{AW{1'b0}}, do_pop_s};
      nxt_avail = (left_s != {(AW+1){1'b0}});
   end

   // Next pointer values, storage update and the post-edge head entry.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      nxt_data = mem_q[rd_ptr_d[AW-1:0]];
   end

   // Pointer and storage registers; reset discards every entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DW{1'b0}};
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/aoi_out_monitor.sv
// Observes the aoi2 output g: synchronises it, debounces it into g_filt,
// timestamps every filtered level change and queues the changes as event
// records that a consumer drains over a valid/ready handshake.
module aoi_out_monitor
   import aoi_mon_pkg::*;
#(
   parameter int SYNC_STAGES   = AOI_SYNC_STAGES,
   parameter int STABLE_CYCLES = AOI_STABLE_CYCLES,
   parameter int CNT_W         = AOI_CNT_W,
   parameter int FIFO_DEPTH    = AOI_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             g_in,
   output logic             g_filt,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic             evt_level,
   output logic [CNT_W-1:0] evt_time,
   output logic             overflow,
   input  logic             ovf_clr
);

   // Same layout as aoi_evt_t, sized by this instance's timestamp width.
   typedef struct packed {
      logic             level;
      logic [CNT_W-1:0] stamp;
   } evt_t;

   localparam int         EVT_W       = $bits(evt_t);
   localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);
   localparam evt_t       EVT_ZERO    = '{level: 1'b0, stamp: {CNT_W{1'b0}}};

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_s;
   logic [7:0]             stab_q, stab_d;
   logic                   g_filt_q, g_filt_d;
   logic [CNT_W-1:0]       ts_q, ts_d;
   logic                   ovf_q, ovf_d;
   logic                   evt_valid_q, evt_valid_d;
   evt_t                   evt_q, evt_d;
   logic                   push_s;
   logic                   pop_s;
   logic                   drop_s;
   logic                   full_s;
   logic                   empty_s;
   logic                   nxt_avail_s;
   evt_t                   push_evt_s;
   evt_t                   nxt_evt_s;
   logic [EVT_W-1:0]       nxt_data_s;

   // Synchroniser chain; runs every cycle regardless of en.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], g_in};
      s_s    = sync_q[SYNC_STAGES-1];
   end

   // Debounce: g_filt follows s only after STABLE_CYCLES disagreeing samples.
   always_comb begin
      stab_d   = stab_q;
      g_filt_d = g_filt_q;
      push_s   = 1'b0;
      if (!en) begin
         stab_d = 8'd0;
      end else if (s_s == g_filt_q) begin
         stab_d = 8'd0;
      end else if (stab_q == STABLE_LAST) begin
         g_filt_d = s_s;
         stab_d   = 8'd0;
         push_s   = 1'b1;
      end else begin
         stab_d = stab_q + 8'd1;
      end
   end

   // Free-running timestamp, frozen while disabled, wraps naturally.
   always_comb begin
      if (en) begin
         ts_d = ts_q + CNT_W'(1);
      end else begin
         ts_d = ts_q;
      end
   end

   // Event record, handshake and sticky overflow (a new drop beats a clear).
   always_comb begin
      push_evt_s.level = s_s;
      push_evt_s.stamp = ts_q;
      pop_s            = evt_valid_q && evt_ready && !empty_s;
      drop_s           = push_s && full_s && !pop_s;
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Registered head view; the payload only moves when a new head exists.
   always_comb begin
      nxt_evt_s   = nxt_data_s;
      evt_valid_d = nxt_avail_s;
      if (nxt_avail_s) begin
         evt_d = nxt_evt_s;
      end else begin
         evt_d = evt_q;
      end
   end

   aoi_evt_fifo #(
      .DW    (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (push_evt_s),
      .pop       (pop_s),
      .full      (full_s),
      .empty     (empty_s),
      .nxt_avail (nxt_avail_s),
      .nxt_data  (nxt_data_s)
   );

   // State registers; reset returns every output to zero immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q      <= {SYNC_STAGES{1'b0}};
         stab_q      <= 8'd0;
         g_filt_q    <= 1'b0;
         ts_q        <= {CNT_W{1'b0}};
         ovf_q       <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_q       <= EVT_ZERO;
      end else begin
         sync_q      <= sync_d;
         stab_q      <= stab_d;
         g_filt_q    <= g_filt_d;
         ts_q        <= ts_d;
         ovf_q       <= ovf_d;
         evt_valid_q <= evt_valid_d;
         evt_q       <= evt_d;
      end
   end

   assign g_filt    = g_filt_q;
   assign evt_valid = evt_valid_q;
   assign evt_level = evt_q.level;
   assign evt_time  = evt_q.stamp;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_aoi_out_monitor.sv
// Bench for aoi_out_monitor: two instances (16-bit and 4-bit timestamps)
// share one stimulus stream; a behavioural model predicts g_filt, the
// handshake, overflow and the event sequence, and a monitor process checks.
`timescale 1ns/1ps
module tb_aoi_out_monitor;

   localparam int SYNC_N   = 2;
   localparam int STABLE_N = 4;
   localparam int DEPTH_N  = 4;
   localparam int NI       = 2;

   logic clk, rst, en, g_in, evt_ready, ovf_clr;
   logic final_chk;

   logic        g_filt_a, evt_valid_a, evt_level_a, overflow_a;
   logic [15:0] evt_time_a;
   logic        g_filt_b, evt_valid_b, evt_level_b, overflow_b;
   logic [3:0]  evt_time_b;

   aoi_out_monitor u_dut_a (
      .clk(clk), .rst(rst), .en(en), .g_in(g_in), .g_filt(g_filt_a),
      .evt_valid(evt_valid_a), .evt_ready(evt_ready), .evt_level(evt_level_a),
      .evt_time(evt_time_a), .overflow(overflow_a), .ovf_clr(ovf_clr)
   );

   aoi_out_monitor #(.CNT_W(4)) u_dut_b (
      .clk(clk), .rst(rst), .en(en), .g_in(g_in), .g_filt(g_filt_b),
      .evt_valid(evt_valid_b), .evt_ready(evt_ready), .evt_level(evt_level_b),
      .evt_time(evt_time_b), .overflow(overflow_b), .ovf_clr(ovf_clr)
   );

   logic        d_gf  [NI];
   logic        d_vld [NI];
   logic        d_lvl [NI];
   logic        d_ovf [NI];
   logic [31:0] d_time[NI];

   always_comb begin
      d_gf[0] = g_filt_a;  d_vld[0] = evt_valid_a; d_lvl[0] = evt_level_a;
      d_ovf[0] = overflow_a; d_time[0] = {16'd0, evt_time_a};
      d_gf[1] = g_filt_b;  d_vld[1] = evt_valid_b; d_lvl[1] = evt_level_b;
      d_ovf[1] = overflow_b; d_time[1] = {28'd0, evt_time_b};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] tmask(input int i);
      return (i == 0) ? 32'h0000_FFFF : 32'h0000_000F;
   endfunction

   // ---------------- reference model ----------------
   logic        sync_m [NI][$];   // delay line of g_in samples
   logic [32:0] exp_q  [NI][$];   // accepted events {level, time}
   int          run_m  [NI];      // consecutive enabled disagreeing samples
   int          occ_m  [NI];
   logic        gf_m   [NI];
   logic        vld_m  [NI];
   logic        ovf_m  [NI];
   logic [31:0] ts_m   [NI];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NI; i++) begin
            sync_m[i].delete();
            for (int k = 0; k < SYNC_N; k++) sync_m[i].push_back(1'b0);
            exp_q[i].delete();
            run_m[i] = 0; occ_m[i] = 0;
            gf_m[i] = 1'b0; vld_m[i] = 1'b0; ovf_m[i] = 1'b0; ts_m[i] = 32'd0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            logic s_v, pop_v, push_v, drop_v;
            int   occ_before;
            s_v = sync_m[i].pop_front();
            sync_m[i].push_back(g_in);
            pop_v  = vld_m[i] && evt_ready;
            push_v = 1'b0;
            drop_v = 1'b0;
            if (en && (s_v != gf_m[i])) begin
               run_m[i]++;
               if (run_m[i] == STABLE_N) begin
                  gf_m[i] = s_v; run_m[i] = 0; push_v = 1'b1;
               end
            end else begin
               run_m[i] = 0;
            end
            occ_before = occ_m[i];
            if (pop_v) occ_m[i]--;
            if (push_v) begin
               if (occ_before < DEPTH_N || pop_v) begin
                  exp_q[i].push_back({s_v, ts_m[i]});
                  occ_m[i]++;
               end else begin
                  drop_v = 1'b1;
               end
            end
            if (drop_v) ovf_m[i] = 1'b1;
            else if (ovf_clr) ovf_m[i] = 1'b0;
            vld_m[i] = (occ_before - (pop_v ? 1 : 0)) > 0;
            if (en) ts_m[i] = (ts_m[i] + 32'd1) & tmask(i);
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int idx,
                      input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] t=%0t got=%0h exp=%0h", name, idx, $time, act, exp);
      end
   endtask

   always @(negedge clk or posedge rst) begin
      if (rst) begin
         #1;
         for (int i = 0; i < NI; i++) begin
            chk("rst_g_filt", i, 33'(d_gf[i]), 33'd0);
            chk("rst_evt_valid", i, 33'(d_vld[i]), 33'd0);
            chk("rst_overflow", i, 33'(d_ovf[i]), 33'd0);
            chk("rst_evt_payload", i, {d_lvl[i], d_time[i]}, 33'd0);
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            chk("g_filt", i, 33'(d_gf[i]), 33'(gf_m[i]));
            chk("evt_valid", i, 33'(d_vld[i]), 33'(vld_m[i]));
            chk("overflow", i, 33'(d_ovf[i]), 33'(ovf_m[i]));
            if (d_vld[i]) begin
               if (exp_q[i].size() == 0) begin
                  chk("unexpected_event", i, {d_lvl[i], d_time[i]}, 33'h1_FFFF_FFFF);
               end else begin
                  chk("event", i, {d_lvl[i], d_time[i]}, exp_q[i][0]);
                  if (evt_ready) void'(exp_q[i].pop_front());
               end
            end
            if (final_chk) chk("leftover_events", i, 33'(exp_q[i].size()), 33'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic toggles(input int n, input int hold);
      for (int k = 0; k < n; k++) begin
         g_in = ~g_in;
         step(hold);
      end
   endtask

   initial begin
      int hold;
      rst = 1'b1; en = 1'b0; g_in = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
      final_chk = 1'b0;
      step(3);
      rst = 1'b0; en = 1'b1;
      step(50);                                   // idle after reset

      g_in = 1'b1; step(12);                      // single rise, held head
      evt_ready = 1'b1; step(4); evt_ready = 1'b0;
      g_in = 1'b0; step(12);

      g_in = 1'b1; step(3); g_in = 1'b0; step(12); // 3-sample glitch
      g_in = 1'b1; step(4); g_in = 1'b0; step(12); // 4-sample pulse
      evt_ready = 1'b1; step(8); evt_ready = 1'b0;

      toggles(5, 8);                              // fill and overflow
      evt_ready = 1'b1; step(8); evt_ready = 1'b0;
      ovf_clr = 1'b1; step(1); ovf_clr = 1'b0; step(2);

      toggles(4, 8);                              // clear coinciding with drop
      g_in = ~g_in; ovf_clr = 1'b1; step(8); ovf_clr = 1'b0; step(2);
      evt_ready = 1'b1; step(8); evt_ready = 1'b0;

      toggles(5, 8);                              // mid-operation reset
      evt_ready = 1'b1; step(2); evt_ready = 1'b0;
      g_in = ~g_in; step(2);
      @(posedge clk); #2;
      rst = 1'b1; g_in = 1'b0;
      step(3);
      rst = 1'b0; evt_ready = 1'b1; step(30);

      @(posedge clk); #2;                         // g_in high through reset
      rst = 1'b1; g_in = 1'b1;
      step(3);
      rst = 1'b0; step(15);

      hold = 0;                                   // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         if (hold == 0) begin
            g_in = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 9);
         end
         hold--;
         en        = ($urandom_range(0, 15) != 0);
         evt_ready = ($urandom_range(0, 3) == 0);
         ovf_clr   = ($urandom_range(0, 19) == 0);
         step(1);
      end

      en = 1'b1; evt_ready = 1'b1; ovf_clr = 1'b0;
      step(20);
      final_chk = 1'b1;
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
